// File: rtl/pc_unit.sv
// rtl/pc_unit.sv - fetch PC register with valid/ready handshake, exception/redirect/stall control, halt
//
// Holds the current fetch PC and presents it to instruction memory with a
// valid/ready handshake. Update priority per clock: exception, redirect,
// return-address-stack pop (PC_RAS_EN only), accepted sequential advance, hold.
//
// Optional feature macro: PC_RAS_EN (adds a circular return-address stack).
//
// Ports:
//   clock         in   1   rising-edge clock
//   reset         in   1   asynchronous, active-high reset
//   stall         in   1   pipeline stall; holds PC
//   redirect_vld  in   1   branch/jump taken this cycle
//   redirect_pc   in   AW  branch/jump target (low two bits dropped)
//   exc_vld       in   1   exception; jump to EXC_PC
//   halt          in   1   stop fetching after the current PC
//   fetch_ready   in   1   imem accepts the request
//   fetch_valid   out  1   request valid for pc_out
//   pc_out        out  AW  current fetch PC
//   pc_plus_inc   out  AW  pc_out + INC (combinational, wraps)
//   misalign      out  1   pulse after an accepted redirect with target[1:0] != 0
//   ras_push      in   1   (PC_RAS_EN) push pc_plus_inc on an accepted fetch
//   ras_pop       in   1   (PC_RAS_EN) load PC from the stack top
//   ras_empty     out  1   (PC_RAS_EN) stack holds no entries
//   ras_top       out  AW  (PC_RAS_EN) newest entry; undefined when empty
module pc_unit #(
  parameter int              AW       = 32,
  parameter logic [AW-1:0]   RESET_PC = AW'(32'h0000_3000),
  parameter logic [AW-1:0]   EXC_PC   = AW'(32'h0000_4180),
  parameter int              INC      = 4
`ifdef PC_RAS_EN
  , parameter int            RAS_DEPTH = 4
`endif
) (
  input  logic          clock,
  input  logic          reset,
  input  logic          stall,
  input  logic          redirect_vld,
  input  logic [AW-1:0] redirect_pc,
  input  logic          exc_vld,
  input  logic          halt,
  input  logic          fetch_ready,
  output logic          fetch_valid,
  output logic [AW-1:0] pc_out,
  output logic [AW-1:0] pc_plus_inc,
  output logic          misalign
`ifdef PC_RAS_EN
  ,
  input  logic          ras_push,
  input  logic          ras_pop,
  output logic          ras_empty,
  output logic [AW-1:0] ras_top
`endif
);

  typedef enum logic [1:0] {ST_BOOT, ST_RUN, ST_HALTED} state_t;

  state_t        state_q, state_d;
  logic [AW-1:0] pc_q, pc_d;
  logic          misalign_q, misalign_d;
  logic          accept;

  // State register
  always_ff @(posedge clock or posedge reset) begin
    if (reset) state_q <= ST_BOOT;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_BOOT:   state_d = ST_RUN;
      ST_RUN:    if (halt && !exc_vld && !redirect_vld) state_d = ST_HALTED;
      ST_HALTED: if (exc_vld || redirect_vld) state_d = ST_RUN;
      default:   state_d = ST_BOOT;
    endcase
  end

  // Output logic
  always_comb begin
    fetch_valid = (state_q == ST_RUN);
  end

  // A handshake completes whenever imem takes the request and the pipe is not
  // stalled, even if a redirect replaces the PC in the same cycle.
  assign accept      = fetch_valid && fetch_ready && !stall;
  assign pc_plus_inc = pc_q + AW'(INC);
  assign pc_out      = pc_q;
  assign misalign    = misalign_q;

`ifdef PC_RAS_EN
  localparam int PW = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] RAS_FULL = CW'(RAS_DEPTH);

  logic [AW-1:0] ras_mem [RAS_DEPTH];
  logic [PW-1:0] ras_wp;      // next write slot; top lives at ras_wp-1
  logic [CW-1:0] ras_cnt;
  logic          do_push, do_pop;

  assign ras_empty = (ras_cnt == '0);
  assign ras_top   = ras_mem[ras_wp - PW'(1)];
  assign do_push   = accept && ras_push;
  assign do_pop    = ras_pop && !ras_empty && !exc_vld && !redirect_vld;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      ras_wp  <= '0;
      ras_cnt <= '0;
    end else if (do_push && do_pop) begin
      ras_wp  <= ras_wp;
      ras_cnt <= ras_cnt;
    end else if (do_push) begin
      ras_wp  <= ras_wp + PW'(1);
      // Full stack overwrites the oldest slot; count saturates.
      ras_cnt <= (ras_cnt == RAS_FULL) ? ras_cnt : ras_cnt + CW'(1);
    end else if (do_pop) begin
      ras_wp  <= ras_wp - PW'(1);
      ras_cnt <= ras_cnt - CW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (do_push && do_pop) ras_mem[ras_wp - PW'(1)] <= pc_plus_inc;
    else if (do_push)      ras_mem[ras_wp]          <= pc_plus_inc;
  end
`endif

  // PC next value in strict priority order
  always_comb begin
    pc_d       = pc_q;
    misalign_d = 1'b0;
    if (exc_vld) begin
      pc_d = EXC_PC;
    end else if (redirect_vld) begin
      pc_d       = {redirect_pc[AW-1:2], 2'b00};
      misalign_d = |redirect_pc[1:0];
    end
`ifdef PC_RAS_EN
    else if (do_pop) begin
      pc_d = ras_top;
    end
`endif
    else if (accept) begin
      pc_d = pc_plus_inc;
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      pc_q       <= RESET_PC;
      misalign_q <= 1'b0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
    end
  end

endmodule

// File: tb/tb_pc_unit.sv
// tb/tb_pc_unit.sv - directed self-checking bench for pc_unit
module tb_pc_unit;

  logic        clock = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect_vld;
  logic [31:0] redirect_pc;
  logic        exc_vld;
  logic        halt;
  logic        fetch_ready;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic [31:0] pc_plus_inc;
  logic        misalign;
`ifdef PC_RAS_EN
  logic        ras_push;
  logic        ras_pop;
  logic        ras_empty;
  logic [31:0] ras_top;
`endif

  int checks   = 0;
  int failures = 0;

  always #5 clock = ~clock;

  pc_unit dut (
    .clock        (clock),
    .reset        (reset),
    .stall        (stall),
    .redirect_vld (redirect_vld),
    .redirect_pc  (redirect_pc),
    .exc_vld      (exc_vld),
    .halt         (halt),
    .fetch_ready  (fetch_ready),
    .fetch_valid  (fetch_valid),
    .pc_out       (pc_out),
    .pc_plus_inc  (pc_plus_inc),
    .misalign     (misalign)
`ifdef PC_RAS_EN
    ,
    .ras_push     (ras_push),
    .ras_pop      (ras_pop),
    .ras_empty    (ras_empty),
    .ras_top      (ras_top)
`endif
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic redirect_to(input logic [31:0] target);
    redirect_vld = 1'b1;
    redirect_pc  = target;
    step();
    redirect_vld = 1'b0;
  endtask

  initial begin
    reset = 1'b1; stall = 1'b0; redirect_vld = 1'b0; redirect_pc = '0;
    exc_vld = 1'b0; halt = 1'b0; fetch_ready = 1'b0;
`ifdef PC_RAS_EN
    ras_push = 1'b0; ras_pop = 1'b0;
`endif
    repeat (2) step();
    check("rst_pc", pc_out, 32'h3000);
    check("rst_fv", {31'd0, fetch_valid}, 32'd0);
    check("rst_mis", {31'd0, misalign}, 32'd0);
    check("rst_pinc", pc_plus_inc, 32'h3004);

    // 1: boot bubble, run, then asynchronous reset mid-run
    reset = 1'b0;
    check("boot_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    check("run_fv", {31'd0, fetch_valid}, 32'd1);
    check("run_pc", pc_out, 32'h3000);
    fetch_ready = 1'b1;
    step(); check("seq1", pc_out, 32'h3004);
    step(); check("seq2", pc_out, 32'h3008);
    #2 reset = 1'b1;
    #1;
    check("async_rst_pc", pc_out, 32'h3000);
    check("async_rst_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    reset = 1'b0;
    check("boot2_fv", {31'd0, fetch_valid}, 32'd0);
    step();
    check("boot2_pc", pc_out, 32'h3000);
    check("boot2_fv1", {31'd0, fetch_valid}, 32'd1);
    step(); check("boot2_seq", pc_out, 32'h3004);

    // 2: not ready holds, stall holds
    fetch_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      check("nrdy_pc", pc_out, 32'h3004);
      check("nrdy_fv", {31'd0, fetch_valid}, 32'd1);
    end
    stall = 1'b1; fetch_ready = 1'b1;
    step(); check("stall_pc", pc_out, 32'h3004);
    stall = 1'b0;
    step(); check("unstall_pc", pc_out, 32'h3008);

    // 3: exception beats redirect and stall; misaligned redirect
    exc_vld = 1'b1; redirect_vld = 1'b1; redirect_pc = 32'h5000; stall = 1'b1;
    step();
    check("exc_pc", pc_out, 32'h4180);
    check("exc_mis", {31'd0, misalign}, 32'd0);
    exc_vld = 1'b0; stall = 1'b0;
    redirect_to(32'h5002);
    check("mis_pc", pc_out, 32'h5000);
    check("mis_pulse", {31'd0, misalign}, 32'd1);
    fetch_ready = 1'b0;
    step();
    check("mis_clear", {31'd0, misalign}, 32'd0);
    check("mis_hold", pc_out, 32'h5000);

    // 4: wrap at top of address space
    redirect_to(32'hFFFF_FFFC);
    check("wrap_pre", pc_out, 32'hFFFF_FFFC);
    check("wrap_pinc", pc_plus_inc, 32'h0);
    fetch_ready = 1'b1;
    step(); check("wrap_pc", pc_out, 32'h0);

    // 5: halt with accepted fetch, then restart by redirect
    fetch_ready = 1'b0;
    redirect_to(32'h3008);
    halt = 1'b1; fetch_ready = 1'b1;
    step();
    check("halt_pc", pc_out, 32'h300C);
    check("halt_fv", {31'd0, fetch_valid}, 32'd0);
    halt = 1'b0;
    step();
    check("halted_pc", pc_out, 32'h300C);
    check("halted_fv", {31'd0, fetch_valid}, 32'd0);
    fetch_ready = 1'b0;
    redirect_to(32'h3100);
    check("resume_pc", pc_out, 32'h3100);
    check("resume_fv", {31'd0, fetch_valid}, 32'd1);
    halt = 1'b1;
    redirect_to(32'h3200);
    halt = 1'b0;
    check("halt_redir_pc", pc_out, 32'h3200);
    check("halt_redir_fv", {31'd0, fetch_valid}, 32'd1);

`ifdef PC_RAS_EN
    // 6: return-address stack
    redirect_to(32'h3000);
    check("ras_empty0", {31'd0, ras_empty}, 32'd1);
    fetch_ready = 1'b1; ras_push = 1'b1;
    step(); ras_push = 1'b0; fetch_ready = 1'b0;
    check("ras_push1_pc", pc_out, 32'h3004);
    redirect_to(32'h3010);
    fetch_ready = 1'b1; ras_push = 1'b1;
    step(); ras_push = 1'b0; fetch_ready = 1'b0;
    check("ras_top", ras_top, 32'h3014);
    check("ras_nonempty", {31'd0, ras_empty}, 32'd0);
    ras_pop = 1'b1;
    step(); check("ras_pop1", pc_out, 32'h3014);
    step(); check("ras_pop2", pc_out, 32'h3004);
    check("ras_empty1", {31'd0, ras_empty}, 32'd1);
    fetch_ready = 1'b1;
    step(); check("ras_pop_empty", pc_out, 32'h3008);
    ras_pop = 1'b0; ras_push = 1'b1;
    repeat (5) step();
    ras_push = 1'b0; fetch_ready = 1'b0;
    check("ras_5push_pc", pc_out, 32'h301C);
    ras_pop = 1'b1;
    for (int i = 0; i < 4; i++) begin
      step();
      check("ras_drain", pc_out, 32'h301C - 32'(4 * i));
    end
    ras_pop = 1'b0;
    check("ras_empty2", {31'd0, ras_empty}, 32'd1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
